// File: rtl/ray_scheduler_pkg.sv
// Shared types and defaults for the ray scheduling path between camera, tracer and framebuffer.
package ray_scheduler_pkg;

  typedef struct packed {
    logic [23:0] x;
    logic [23:0] y;
    logic [23:0] z;
  } fp24_vec3;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWait,
    StWrite,
    StDone
  } rt_sched_state_t;

  localparam int unsigned SCHED_DEFAULT_MAX_BOUNCES = 4;

endpackage

// File: rtl/ray_scheduler_pixel_scan_counter.sv
// Raster-order pixel position; wraps back to (0,0) after the last pixel so each frame starts clean.
module pixel_scan_counter #(
  parameter int unsigned WIDTH  = 1280,
  parameter int unsigned HEIGHT = 720,
  localparam int unsigned HW    = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int unsigned VW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          last
);

  localparam logic [HW-1:0] HLast = HW'(WIDTH - 1);
  localparam logic [VW-1:0] VLast = VW'(HEIGHT - 1);

  assign last = (h == HLast) && (v == VLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h <= '0;
      v <= '0;
    end else if (advance) begin
      if (h == HLast) begin
        h <= '0;
        v <= (v == VLast) ? '0 : v + VW'(1);
      end else begin
        h <= h + HW'(1);
      end
    end
  end

endmodule

// File: rtl/ray_scheduler.sv
// Frame sequencer for a single-ray tracer: fetch primary ray, issue and re-issue bounces, then
// write the final colour. Exactly one ray is in flight at any time.
module ray_scheduler
  import ray_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH       = 1280,
  parameter int unsigned HEIGHT      = 720,
  parameter int unsigned MAX_BOUNCES = SCHED_DEFAULT_MAX_BOUNCES,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        timeout_err,
  output logic        cam_req,
  output logic [10:0] cam_pixel_h,
  output logic [9:0]  cam_pixel_v,
  input  logic        cam_valid,
  input  fp24_vec3    cam_origin,
  input  fp24_vec3    cam_dir,
  output logic        trace_valid,
  output fp24_vec3    trace_origin,
  output fp24_vec3    trace_dir,
  output logic [10:0] trace_pixel_h,
  output logic [9:0]  trace_pixel_v,
  input  logic        trace_done,
  input  fp24_vec3    trace_color,
  input  logic        trace_bounce,
  input  fp24_vec3    trace_next_origin,
  input  fp24_vec3    trace_next_dir,
  output logic        fb_valid,
  input  logic        fb_ready,
  output logic [10:0] fb_h,
  output logic [9:0]  fb_v,
  output fp24_vec3    fb_color
);

  localparam int unsigned HW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned VW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned BW = $clog2(MAX_BOUNCES + 1);

  localparam logic [BW-1:0] BounceMax = BW'(MAX_BOUNCES);
  // Timer starts at 0 in the first WAIT cycle, so this is the TIMEOUT-th cycle without a result.
  localparam logic [15:0]   TimerLast = 16'(TIMEOUT - 1);

  rt_sched_state_t state_q;
  logic [BW-1:0]   bounce_q;
  logic [15:0]     timer_q;

  logic [HW-1:0] scan_h;
  logic [VW-1:0] scan_v;
  logic          scan_last;
  logic          scan_advance;

  assign scan_advance = (state_q == StWrite) && fb_valid && fb_ready;

  pixel_scan_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .advance (scan_advance),
    .h       (scan_h),
    .v       (scan_v),
    .last    (scan_last)
  );

  // Pixel tags only move on an accepted FB write, so they are stable across the whole pixel.
  assign cam_pixel_h   = 11'(scan_h);
  assign cam_pixel_v   = 10'(scan_v);
  assign trace_pixel_h = 11'(scan_h);
  assign trace_pixel_v = 10'(scan_v);
  assign fb_h          = 11'(scan_h);
  assign fb_v          = 10'(scan_v);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      bounce_q     <= '0;
      timer_q      <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
      timeout_err  <= 1'b0;
      cam_req      <= 1'b0;
      trace_valid  <= 1'b0;
      trace_origin <= '0;
      trace_dir    <= '0;
      fb_valid     <= 1'b0;
      fb_color     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            busy        <= 1'b1;
            timeout_err <= 1'b0;
            bounce_q    <= '0;
            cam_req     <= 1'b1;
            state_q     <= StFetch;
          end
        end
        StFetch: begin
          if (cam_valid) begin
            cam_req      <= 1'b0;
            trace_origin <= cam_origin;
            trace_dir    <= cam_dir;
            trace_valid  <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          trace_valid <= 1'b0;
          bounce_q    <= bounce_q + BW'(1);
          timer_q     <= '0;
          state_q     <= StWait;
        end
        StWait: begin
          timer_q <= timer_q + 16'd1;
          // A result arriving on the timeout cycle still counts.
          if (trace_done) begin
            fb_color <= trace_color;
            if (trace_bounce && (bounce_q < BounceMax)) begin
              trace_origin <= trace_next_origin;
              trace_dir    <= trace_next_dir;
              trace_valid  <= 1'b1;
              state_q      <= StIssue;
            end else begin
              fb_valid <= 1'b1;
              state_q  <= StWrite;
            end
          end else if (timer_q == TimerLast) begin
            fb_color    <= '0;
            timeout_err <= 1'b1;
            fb_valid    <= 1'b1;
            state_q     <= StWrite;
          end
        end
        StWrite: begin
          if (fb_ready) begin
            fb_valid <= 1'b0;
            bounce_q <= '0;
            if (scan_last) begin
              frame_done <= 1'b1;
              state_q    <= StDone;
            end else begin
              cam_req <= 1'b1;
              state_q <= StFetch;
            end
          end
        end
        StDone: begin
          frame_done  <= 1'b0;
          frame_count <= frame_count + 16'd1;
          busy        <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
